ifu_prefetch: RTL and testbench

//  Instruction prefetch unit between the instruction memory port and the core's if_id stage.

---
 rtl/ifu_prefetch_if.sv | 40 ++++
 rtl/ifu_prefetch.sv | 168 ++++++++++++++++
 tb/tb_ifu_prefetch.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_prefetch_if.sv
// Bundles the memory fetch bus and the instruction delivery handshake of the prefetch unit.
// No logic, so no latency.
// Backpressure travels on mem_gnt_i (memory side) and inst_ready_i (core side).
interface ifu_prefetch_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i;

    // The prefetch unit's view of the bus.
    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i,
        output inst_valid_o,
        output inst_o,
        output inst_addr_o,
        input  inst_ready_i
    );

    // The memory and core view of the bus.
    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i,
        input  inst_valid_o,
        input  inst_o,
        input  inst_addr_o,
        output inst_ready_i
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Purpose: instruction prefetch unit that fetches in-order words and queues them with their addresses for the core.
// Latency: with a zero-wait memory, inst_valid_o rises 2 cycles after the first request; it then sustains 1 instruction per cycle.
// Backpressure: the request is held off while queued plus outstanding fetches reach DEPTH; inst_ready_i pops the head.
module ifu_prefetch #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           jump_en_i,
    input  logic [31:0]    jump_addr_i,
    ifu_prefetch_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW:0]   CREDIT_LIM = (CW+1)'(DEPTH);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [31:0]   pc;
    logic [31:0]   resp_addr;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] out_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_nxt;
    logic [CW-1:0] fifo_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_addr [DEPTH];

    logic [CW:0]   inflight;
    logic [CW:0]   drop_jump;
    logic          req_int;
    logic          gnt_acc;
    logic          fetch_fire;
    logic          drop;
    logic          push;
    logic          pop;
    logic          fifo_empty;

    // Credit: queued entries plus outstanding fetches never exceed the FIFO size,
    // so every response that is kept always has a slot waiting for it.
    assign inflight   = {1'b0, fifo_cnt} + {1'b0, out_cnt};
    assign req_int    = (state == S_FETCH) && (inflight < CREDIT_LIM);
    // A grant that coincides with a jump still produces a response, which must be dropped.
    assign gnt_acc    = req_int & bus.mem_gnt_i;
    assign fetch_fire = gnt_acc & ~jump_en_i;
    assign drop       = bus.mem_rvalid_i & (jump_en_i | (drop_cnt != '0));
    assign push       = bus.mem_rvalid_i & ~drop;
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = ~fifo_empty & bus.inst_ready_i & ~jump_en_i;

    // Responses still owed to us at a jump all become stale; the one arriving now is dropped on the spot.
    assign drop_jump  = {1'b0, drop_cnt} + {1'b0, out_cnt} + {{CW{1'b0}}, gnt_acc}
                      - {{CW{1'b0}}, bus.mem_rvalid_i};

    assign bus.mem_req_o    = req_int & ~jump_en_i;
    assign bus.mem_addr_o   = pc;
    assign bus.inst_valid_o = ~fifo_empty;
    assign bus.inst_o       = fifo_empty ? NOP_INST : fifo_inst[rd_ptr];
    assign bus.inst_addr_o  = fifo_empty ? 32'h0 : fifo_addr[rd_ptr];

    // Next-value logic for the stale-response and outstanding-fetch counters.
    always_comb begin
        drop_nxt = drop_cnt;
        out_nxt  = out_cnt;
        if (jump_en_i) begin
            drop_nxt = drop_jump[CW-1:0];
            out_nxt  = '0;
        end else begin
            if (drop) begin
                drop_nxt = drop_cnt - CNT_ONE;
            end
            if (fetch_fire && !push) begin
                out_nxt = out_cnt + CNT_ONE;
            end else if (!fetch_fire && push) begin
                out_nxt = out_cnt - CNT_ONE;
            end
        end
    end

    // Control FSM: boot for one cycle, fetch, and sit in drain until stale responses are gone.
    always_comb begin
        state_nxt = state;
        if (jump_en_i) begin
            state_nxt = (drop_nxt != '0) ? S_DRAIN : S_FETCH;
        end else begin
            case (state)
                S_BOOT:  state_nxt = S_FETCH;
                S_FETCH: state_nxt = S_FETCH;
                S_DRAIN: state_nxt = (drop_nxt == '0) ? S_FETCH : S_DRAIN;
                default: state_nxt = S_BOOT;
            endcase
        end
    end

    // State, fetch PC, response address and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_BOOT;
            pc        <= RESET_ADDR;
            resp_addr <= RESET_ADDR;
            out_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            out_cnt  <= out_nxt;
            drop_cnt <= drop_nxt;
            if (jump_en_i) begin
                pc        <= jump_addr_i;
                resp_addr <= jump_addr_i;
            end else begin
                if (fetch_fire) begin
                    pc <= pc + 32'd4;
                end
                if (push) begin
                    resp_addr <= resp_addr + 32'd4;
                end
            end
        end
    end

    // FIFO pointers and occupancy; a jump empties the queue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (jump_en_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_ONE;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - CNT_ONE;
            end
        end
    end

    // FIFO storage; contents are only observed through valid entries, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= bus.mem_rdata_i;
            fifo_addr[wr_ptr] <= resp_addr;
        end
    end

    // A response with nothing outstanding and nothing to drop means the memory broke ordering.
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rstn)
        !(bus.mem_rvalid_i && (out_cnt == '0) && (drop_cnt == '0)));
endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a small in-order memory responder.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// Read data for address A is ~A so data and address can be cross-checked.
module tb_ifu_prefetch;
    logic        clk;
    logic        rstn;
    logic        jump_en;
    logic [31:0] jump_addr;

    ifu_prefetch_if bus();

    ifu_prefetch #(
        .DEPTH      (4),
        .RESET_ADDR (32'h0000_0000),
        .NOP_INST   (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .jump_en_i   (jump_en),
        .jump_addr_i (jump_addr),
        .bus         (bus.master)
    );

    int total;
    int bad;
    int cyc;
    int lat;
    int first_req;
    int first_val;
    logic gnt_en;
    logic hold_resp;
    logic force_gnt;
    logic        last_req;
    logic [31:0] last_addr;
    logic        last_valid;
    logic [31:0] grants[$];
    logic [31:0] pops_addr[$];
    logic [31:0] pops_inst[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: memory drives gnt/rvalid, then the cycle is observed and recorded.
    task automatic step();
        if (pend_due.size() > 0 && pend_due[0] <= cyc && !hold_resp) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = ~pend_addr[0];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = 32'h0;
        end
        bus.mem_gnt_i = gnt_en;
        #1;
        last_req   = bus.mem_req_o;
        last_addr  = bus.mem_addr_o;
        last_valid = bus.inst_valid_o;
        if (bus.mem_req_o && first_req < 0) first_req = cyc;
        if (bus.inst_valid_o && first_val < 0) first_val = cyc;
        if (bus.mem_gnt_i && (bus.mem_req_o || force_gnt)) begin
            grants.push_back(bus.mem_addr_o);
            pend_addr.push_back(bus.mem_addr_o);
            pend_due.push_back(cyc + lat);
        end
        if (bus.inst_valid_o && bus.inst_ready_i && !jump_en) begin
            pops_addr.push_back(bus.inst_addr_o);
            pops_inst.push_back(bus.inst_o);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic assert_reset();
        rstn             = 1'b0;
        jump_en          = 1'b0;
        jump_addr        = 32'h0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        grants.delete();
        pops_addr.delete();
        pops_inst.delete();
        pend_addr.delete();
        pend_due.delete();
        first_req = -1;
        first_val = -1;
        hold_resp = 1'b0;
        force_gnt = 1'b0;
        gnt_en    = 1'b1;
        lat       = 1;
        cyc       = 0;
        rstn      = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req"},   {31'h0, bus.mem_req_o},    32'h0);
        chk({tag, " addr"},  bus.mem_addr_o,            32'h0);
        chk({tag, " valid"}, {31'h0, bus.inst_valid_o}, 32'h0);
        chk({tag, " inst"},  bus.inst_o,                32'h0000_0013);
        chk({tag, " iaddr"}, bus.inst_addr_o,           32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.inst_ready_i = 1'b1;
        gnt_en = 1'b0; hold_resp = 1'b0; force_gnt = 1'b0; lat = 1;
        assert_reset();
        chk_reset_outputs("reset");

        // T1: streaming at one instruction per cycle.
        release_reset();
        bus.inst_ready_i = 1'b1;
        run(10);
        chk("t1 latency", 32'(first_val - first_req), 32'd2);
        chk("t1 pop count", 32'(pops_addr.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t1 pop%0d addr", i), pops_addr[i], 32'(i * 4));
            chk($sformatf("t1 pop%0d inst", i), pops_inst[i], ~32'(i * 4));
        end

        // T2: core stalls, FIFO fills, then drains in order.
        assert_reset();
        release_reset();
        bus.inst_ready_i = 1'b0;
        run(8);
        chk("t2 grant count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t2 grant%0d", i), grants[i], 32'(i * 4));
        chk("t2 req off", {31'h0, last_req}, 32'h0);
        chk("t2 full valid", {31'h0, last_valid}, 32'h1);
        bus.inst_ready_i = 1'b1;
        run(8);
        for (int i = 0; i < 4; i++) chk($sformatf("t2 pop%0d addr", i), pops_addr[i], 32'(i * 4));
        chk("t2 resume addr", grants[4], 32'h10);

        // T3: jump with two responses outstanding.
        assert_reset();
        release_reset();
        bus.inst_ready_i = 1'b1;
        run(4);
        hold_resp = 1'b1;
        step();
        gnt_en = 1'b0; jump_en = 1'b1; jump_addr = 32'h100;
        step();
        chk("t3 req on jump", {31'h0, last_req}, 32'h0);
        jump_en = 1'b0; gnt_en = 1'b1; hold_resp = 1'b0;
        pops_addr.delete(); pops_inst.delete();
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("t3 drain%0d req", i), {31'h0, last_req}, 32'h0);
            chk($sformatf("t3 drain%0d valid", i), {31'h0, last_valid}, 32'h0);
        end
        step();
        chk("t3 restart req", {31'h0, last_req}, 32'h1);
        chk("t3 restart addr", last_addr, 32'h100);
        run(4);
        chk("t3 first pop addr", pops_addr[0], 32'h100);
        chk("t3 first pop inst", pops_inst[0], ~32'h100);

        // T4: jump coincides with a grant and a response.
        assert_reset();
        release_reset();
        lat = 2;
        bus.inst_ready_i = 1'b1;
        run(5);
        jump_en = 1'b1; jump_addr = 32'h200; force_gnt = 1'b1;
        step();
        chk("t4 granted addr", last_addr, 32'h10);
        jump_en = 1'b0; force_gnt = 1'b0;
        pops_addr.delete(); pops_inst.delete();
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("t4 drain%0d valid", i), {31'h0, last_valid}, 32'h0);
            chk($sformatf("t4 drain%0d req", i), {31'h0, last_req}, 32'h0);
        end
        step();
        chk("t4 restart req", {31'h0, last_req}, 32'h1);
        chk("t4 restart addr", last_addr, 32'h200);
        run(4);
        chk("t4 pop count", 32'(pops_addr.size()), 32'd2);
        chk("t4 pop0 addr", pops_addr[0], 32'h200);
        chk("t4 pop1 addr", pops_addr[1], 32'h204);

        // T5: address wrap at the top of the address space.
        assert_reset();
        release_reset();
        bus.inst_ready_i = 1'b1;
        jump_en = 1'b1; jump_addr = 32'hFFFF_FFF8;
        step();
        jump_en = 1'b0;
        run(3);
        gnt_en = 1'b0;
        run(3);
        chk("t5 grant count", 32'(grants.size()), 32'd3);
        chk("t5 grant0", grants[0], 32'hFFFF_FFF8);
        chk("t5 grant1", grants[1], 32'hFFFF_FFFC);
        chk("t5 grant2", grants[2], 32'h0000_0000);
        chk("t5 pop0 addr", pops_addr[0], 32'hFFFF_FFF8);
        chk("t5 pop1 addr", pops_addr[1], 32'hFFFF_FFFC);
        chk("t5 pop2 addr", pops_addr[2], 32'h0000_0000);
        chk("t5 pop2 inst", pops_inst[2], 32'hFFFF_FFFF);

        // T6: reset with a full FIFO.
        assert_reset();
        release_reset();
        bus.inst_ready_i = 1'b0;
        run(8);
        chk("t6 full valid", {31'h0, last_valid}, 32'h1);
        assert_reset();
        chk_reset_outputs("t6 reset");
        release_reset();
        bus.inst_ready_i = 1'b1;
        run(5);
        chk("t6 restart grant", grants[0], 32'h0);
        chk("t6 restart pop", pops_addr[0], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
